// File: rtl/bt656_pkg.sv
// Shared types, constants and the XY protection check for the BT.656 receiver.
package bt656_pkg;

    // Timing-reference search states: idle data, then the FF 00 00 preamble.
    typedef enum logic [1:0] {
        S_DATA,
        S_FF,
        S_00A,
        S_00B
    } trs_state_t;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    // Bit positions inside the XY status byte.
    localparam int XY_ONE_BIT = 7;
    localparam int XY_F_BIT   = 6;
    localparam int XY_V_BIT   = 5;
    localparam int XY_H_BIT   = 4;

    // True when the XY byte has its fixed 1 bit and matching protection bits.
    function automatic logic xy_valid(input logic [7:0] xy);
        logic       f;
        logic       v;
        logic       h;
        logic [3:0] prot;
        f    = xy[XY_F_BIT];
        v    = xy[XY_V_BIT];
        h    = xy[XY_H_BIT];
        prot = {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        return xy[XY_ONE_BIT] && (xy[3:0] == prot);
    endfunction

endpackage

// File: rtl/bt656_trs_detector.sv
// Finds FF 00 00 XY timing references in the registered byte stream and
// decodes the XY byte into SAV/EAV strobes with their F and V flags.
module bt656_trs_detector
    import bt656_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    output logic       sav,
    output logic       eav,
    output logic       f,
    output logic       v,
    output logic       xy_error
);

    trs_state_t state_reg;
    trs_state_t state_next;

    // Preamble state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_DATA;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and XY decode; strobes are only meaningful in S_00B.
    always_comb begin
        state_next = S_DATA;
        sav        = 1'b0;
        eav        = 1'b0;
        xy_error   = 1'b0;
        f          = data[XY_F_BIT];
        v          = data[XY_V_BIT];
        case (state_reg)
            S_DATA: begin
                state_next = (data == TRS_FF) ? S_FF : S_DATA;
            end
            S_FF: begin
                if (data == TRS_00) begin
                    state_next = S_00A;
                end else if (data == TRS_FF) begin
                    state_next = S_FF;
                end else begin
                    state_next = S_DATA;
                end
            end
            S_00A: begin
                state_next = (data == TRS_00) ? S_00B : S_DATA;
            end
            S_00B: begin
                state_next = S_DATA;
                if (xy_valid(data)) begin
                    sav = ~data[XY_H_BIT];
                    eav = data[XY_H_BIT];
                end else begin
                    xy_error = 1'b1;
                end
            end
            default: begin
                state_next = S_DATA;
            end
        endcase
    end

endmodule

// File: rtl/bt656_decoder.sv
// BT.656 receiver: recovers YCbCr pixels, x/y coordinates, field and lock
// status from the embedded-sync byte stream of the TV decoder.
// Optional feature macro BT656_DEINTERLACE_EN: when defined, the row output
// is 2*line + F (interleaved frame rows); otherwise it is the line in field.
module bt656_decoder
    import bt656_pkg::*;
#(
    parameter int ACTIVE_WIDTH = 720
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [7:0] td_data_i,
    output logic       pixel_valid_o,
    output logic [7:0] y_o,
    output logic [7:0] cb_o,
    output logic [7:0] cr_o,
    output logic [9:0] x_pixel_coord_o,
    output logic [9:0] y_pixel_coord_o,
    output logic       field_o,
    output logic       field_start_o,
    output logic       locked_o,
    output logic       sync_error_o
);

    localparam logic [9:0] X_LIMIT  = 10'(ACTIVE_WIDTH);
    localparam logic [9:0] LINE_MAX = 10'd1023;

    logic [7:0] data_reg;
    logic       active_reg;
    logic       line_active_reg;
    logic       overflow_reg;
    logic [1:0] phase_reg;
    logic [9:0] x_reg;
    logic [9:0] line_reg;
    logic       f_reg;
    logic       v_reg;
    logic       locked_reg;
    logic [7:0] cb_hold_reg;
    logic [7:0] y0_hold_reg;
    logic [7:0] cr_hold_reg;

    logic       sav;
    logic       eav;
    logic       xy_f;
    logic       xy_v;
    logic       xy_error;

    logic       is_ff;
    logic       v_fall;
    logic [7:0] pix_y;
    logic [7:0] pix_cr;
    logic [9:0] row;

    bt656_trs_detector u_trs (
        .clk      (clock_i),
        .rst_n    (reset_i),
        .data     (data_reg),
        .sav      (sav),
        .eav      (eav),
        .f        (xy_f),
        .v        (xy_v),
        .xy_error (xy_error)
    );

    // Pixel assembly helpers: phase 2 emits (Y0,Cb,Cr), phase 3 emits (Y1,Cb,Cr).
    always_comb begin
        is_ff  = (data_reg == TRS_FF);
        v_fall = sav && v_reg && !xy_v;
        pix_y  = phase_reg[0] ? data_reg : y0_hold_reg;
        pix_cr = phase_reg[0] ? cr_hold_reg : data_reg;
`ifdef BT656_DEINTERLACE_EN
        row    = 10'({line_reg, f_reg});
`else
        row    = line_reg;
`endif
    end

    assign locked_o = locked_reg;

    // Input capture, line/pixel counters and registered outputs.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            data_reg        <= '0;
            active_reg      <= 1'b0;
            line_active_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            phase_reg       <= '0;
            x_reg           <= '0;
            line_reg        <= '0;
            f_reg           <= 1'b0;
            v_reg           <= 1'b0;
            locked_reg      <= 1'b0;
            cb_hold_reg     <= '0;
            y0_hold_reg     <= '0;
            cr_hold_reg     <= '0;
            pixel_valid_o   <= 1'b0;
            y_o             <= '0;
            cb_o            <= '0;
            cr_o            <= '0;
            x_pixel_coord_o <= '0;
            y_pixel_coord_o <= '0;
            field_o         <= 1'b0;
            field_start_o   <= 1'b0;
            sync_error_o    <= 1'b0;
        end else begin
            data_reg      <= td_data_i;
            pixel_valid_o <= 1'b0;
            field_start_o <= 1'b0;
            sync_error_o  <= xy_error;

            if (sav) begin
                f_reg   <= xy_f;
                v_reg   <= xy_v;
                field_o <= xy_f;
                if (v_fall) begin
                    field_start_o <= 1'b1;
                    locked_reg    <= 1'b1;
                    line_reg      <= '0;
                end
                // The SAV that completes lock already opens the first line.
                if (!xy_v && (locked_reg || v_fall)) begin
                    active_reg      <= 1'b1;
                    line_active_reg <= 1'b1;
                    x_reg           <= '0;
                    phase_reg       <= '0;
                    overflow_reg    <= 1'b0;
                end
            end

            if (eav) begin
                active_reg      <= 1'b0;
                line_active_reg <= 1'b0;
                if (line_active_reg && (line_reg != LINE_MAX)) begin
                    line_reg <= line_reg + 10'd1;
                end
            end

            if (active_reg) begin
                if (is_ff) begin
                    // Preamble ends the active region; a partial group is dropped.
                    active_reg <= 1'b0;
                    phase_reg  <= '0;
                    if (phase_reg != 2'd0) begin
                        sync_error_o <= 1'b1;
                    end
                end else begin
                    phase_reg <= phase_reg + 2'd1;
                    case (phase_reg)
                        2'd0:    cb_hold_reg <= data_reg;
                        2'd1:    y0_hold_reg <= data_reg;
                        2'd2:    cr_hold_reg <= data_reg;
                        default: cr_hold_reg <= cr_hold_reg;
                    endcase
                    if (phase_reg[1]) begin
                        if (x_reg < X_LIMIT) begin
                            pixel_valid_o   <= 1'b1;
                            y_o             <= pix_y;
                            cb_o            <= cb_hold_reg;
                            cr_o            <= pix_cr;
                            x_pixel_coord_o <= x_reg;
                            y_pixel_coord_o <= row;
                            x_reg           <= x_reg + 10'd1;
                        end else if (!overflow_reg) begin
                            // Over-long line: flag it once, drop the excess.
                            sync_error_o <= 1'b1;
                            overflow_reg <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bt656_decoder.sv
// Directed-vector bench for bt656_decoder: table-driven byte/expectation
// records plus hand-written sequences for full lines, overflow and reset.
module tb_bt656_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] td;
    logic       pixel_valid;
    logic [7:0] y_val;
    logic [7:0] cb_val;
    logic [7:0] cr_val;
    logic [9:0] x_coord;
    logic [9:0] y_coord;
    logic       field;
    logic       field_start;
    logic       locked;
    logic       sync_error;

    bt656_decoder #(.ACTIVE_WIDTH(720)) dut (
        .clock_i         (clk),
        .reset_i         (rst_n),
        .td_data_i       (td),
        .pixel_valid_o   (pixel_valid),
        .y_o             (y_val),
        .cb_o            (cb_val),
        .cr_o            (cr_val),
        .x_pixel_coord_o (x_coord),
        .y_pixel_coord_o (y_coord),
        .field_o         (field),
        .field_start_o   (field_start),
        .locked_o        (locked),
        .sync_error_o    (sync_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic [9:0] x;
        logic [9:0] row;
        logic       fld;
        logic       fs;
        logic       err;
        logic       lk;
    } vec_t;

    vec_t vq[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Event monitor, sampled 1 ns after each rising edge.
    int         pix_cnt  = 0;
    int         err_cnt  = 0;
    int         fs_cnt   = 0;
    logic [9:0] last_x   = '0;
    logic [9:0] last_row = '0;

    always @(posedge clk) begin
        #1;
        if (pixel_valid) begin
            pix_cnt  <= pix_cnt + 1;
            last_x   <= x_coord;
            last_row <= y_coord;
        end
        if (sync_error)  err_cnt <= err_cnt + 1;
        if (field_start) fs_cnt  <= fs_cnt + 1;
    end

    function automatic logic [9:0] row_of(input int line, input logic f);
`ifdef BT656_DEINTERLACE_EN
        return 10'(2 * line + int'(f));
`else
        return 10'(line + 0 * int'(f));
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic p_nop(input logic [7:0] d, input logic lk);
        vec_t e;
        e = '{d: d, v: 1'b0, y: 8'h0, cb: 8'h0, cr: 8'h0, x: 10'h0, row: 10'h0,
              fld: 1'b0, fs: 1'b0, err: 1'b0, lk: lk};
        vq.push_back(e);
    endtask

    task automatic p_px(input logic [7:0] d, input logic [7:0] y, input logic [7:0] cb,
                        input logic [7:0] cr, input int x, input int line, input logic f);
        vec_t e;
        e = '{d: d, v: 1'b1, y: y, cb: cb, cr: cr, x: 10'(x), row: row_of(line, f),
              fld: f, fs: 1'b0, err: 1'b0, lk: 1'b1};
        vq.push_back(e);
    endtask

    task automatic p_trs(input logic [7:0] xy, input logic fs, input logic err,
                         input logic lk_pre, input logic lk_post);
        vec_t e;
        p_nop(8'hFF, lk_pre);
        p_nop(8'h00, lk_pre);
        p_nop(8'h00, lk_pre);
        e = '{d: xy, v: 1'b0, y: 8'h0, cb: 8'h0, cr: 8'h0, x: 10'h0, row: 10'h0,
              fld: 1'b0, fs: fs, err: err, lk: lk_post};
        vq.push_back(e);
    endtask

    task automatic check_vec(input string tag, input int i, input vec_t e);
        string nm;
        nm = $sformatf("%s[%0d]", tag, i);
        chk({nm, ".valid"},  64'(pixel_valid), 64'(e.v));
        chk({nm, ".fstart"}, 64'(field_start), 64'(e.fs));
        chk({nm, ".syncerr"}, 64'(sync_error), 64'(e.err));
        chk({nm, ".locked"}, 64'(locked), 64'(e.lk));
        if (e.v) begin
            chk({nm, ".ycbcr"}, 64'({y_val, cb_val, cr_val}), 64'({e.y, e.cb, e.cr}));
            chk({nm, ".x"},     64'(x_coord), 64'(e.x));
            chk({nm, ".row"},   64'(y_coord), 64'(e.row));
            chk({nm, ".field"}, 64'(field), 64'(e.fld));
        end
    endtask

    // Outputs for byte k are visible on the falling edge two bytes later.
    task automatic run_table(input string tag);
        int n;
        n = vq.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) check_vec(tag, i - 2, vq[i - 2]);
            td = (i < n) ? vq[i].d : 8'h10;
        end
        vq.delete();
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        td = b;
    endtask

    task automatic send_trs(input logic [7:0] xy);
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        send(xy);
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) send(8'(16 + (i % 200)));
    endtask

    task automatic check_zero(input string name);
        chk(name, 64'({pixel_valid, y_val, cb_val, cr_val, x_coord, y_coord,
                       field, field_start, locked, sync_error}), 64'h0);
    endtask

    int c0;
    int e0;
    int f0;

    initial begin
        rst_n = 1'b0;
        td    = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;

        // Bring-up: blanking SAV, V falls, first two pixels, EAV.
        p_trs(8'hAB, 1'b0, 1'b0, 1'b0, 1'b0);
        p_trs(8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
        p_nop(8'h10, 1'b1);
        p_nop(8'h20, 1'b1);
        p_px(8'h30, 8'h20, 8'h10, 8'h30, 0, 0, 1'b0);
        p_px(8'h40, 8'h40, 8'h10, 8'h30, 1, 0, 1'b0);
        p_trs(8'h9D, 1'b0, 1'b0, 1'b1, 1'b1);
        run_table("bringup");

        // Bad XY is ignored; next line of 6 bytes ends mid-group.
        p_trs(8'h81, 1'b0, 1'b1, 1'b1, 1'b1);
        p_nop(8'h10, 1'b1);
        p_nop(8'h20, 1'b1);
        p_nop(8'h30, 1'b1);
        p_nop(8'h40, 1'b1);
        p_trs(8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        p_nop(8'h11, 1'b1);
        p_nop(8'h22, 1'b1);
        p_px(8'h33, 8'h22, 8'h11, 8'h33, 0, 1, 1'b0);
        p_px(8'h44, 8'h44, 8'h11, 8'h33, 1, 1, 1'b0);
        p_nop(8'h55, 1'b1);
        p_nop(8'h66, 1'b1);
        p_nop(8'hFF, 1'b1);
        vq[vq.size() - 1].err = 1'b1;
        p_nop(8'h00, 1'b1);
        p_nop(8'h00, 1'b1);
        p_nop(8'h9D, 1'b1);
        run_table("badxy_short");

        // Field 1: EC blanking then C7 starts the field.
        p_trs(8'hEC, 1'b0, 1'b0, 1'b1, 1'b1);
        p_trs(8'hC7, 1'b1, 1'b0, 1'b1, 1'b1);
        p_nop(8'h01, 1'b1);
        p_nop(8'h02, 1'b1);
        p_px(8'h03, 8'h02, 8'h01, 8'h03, 0, 0, 1'b1);
        p_px(8'h04, 8'h04, 8'h01, 8'h03, 1, 0, 1'b1);
        p_trs(8'hF1, 1'b0, 1'b0, 1'b1, 1'b1);
        run_table("field1");

        // Full 1440-byte line, then the next line's row.
        send_trs(8'hAB);
        send_trs(8'h80);
        c0 = pix_cnt;
        e0 = err_cnt;
        send_line(1440);
        send_trs(8'h9D);
        chk("fullline.pixels", 64'(pix_cnt - c0), 64'd720);
        chk("fullline.syncerr", 64'(err_cnt - e0), 64'd0);
        chk("fullline.last_x", 64'(last_x), 64'd719);
        chk("fullline.row", 64'(last_row), 64'(row_of(0, 1'b0)));
        c0 = pix_cnt;
        send_trs(8'h80);
        send(8'hC0);
        send(8'hD0);
        send(8'hE0);
        send(8'hF0);
        send_trs(8'h9D);
        chk("nextline.pixels", 64'(pix_cnt - c0), 64'd2);
        chk("nextline.row", 64'(last_row), 64'(row_of(1, 1'b0)));
        chk("nextline.last_x", 64'(last_x), 64'd1);

        // Over-long 1444-byte line: 720 pixels, one error.
        send_trs(8'h80);
        c0 = pix_cnt;
        e0 = err_cnt;
        send_line(1444);
        send_trs(8'h9D);
        chk("longline.pixels", 64'(pix_cnt - c0), 64'd720);
        chk("longline.syncerr", 64'(err_cnt - e0), 64'd1);
        chk("longline.last_x", 64'(last_x), 64'd719);

        // One-cycle reset in the middle of an active line.
        send_trs(8'h80);
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        @(negedge clk);
        rst_n = 1'b0;
        td    = 8'hA4;
        @(negedge clk);
        check_zero("midreset.outputs");
        rst_n = 1'b1;
        td    = 8'hA5;
        c0 = pix_cnt;
        send_line(8);
        send_trs(8'h80);
        send_line(4);
        send_trs(8'h9D);
        send(8'h10);
        send(8'h10);
        chk("postreset.nopixels", 64'(pix_cnt - c0), 64'd0);
        chk("postreset.locked", 64'(locked), 64'd0);
        f0 = fs_cnt;
        send_trs(8'hAB);
        send_trs(8'h80);
        send(8'hB0);
        send(8'hB1);
        send(8'hB2);
        send(8'hB3);
        send_trs(8'h9D);
        send(8'h10);
        send(8'h10);
        chk("relock.fstart", 64'(fs_cnt - f0), 64'd1);
        chk("relock.locked", 64'(locked), 64'd1);
        chk("relock.pixels", 64'(pix_cnt - c0), 64'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
